speed_boost_ctrl: RTL
=====================

Name: speed_boost_ctrl

Overview:
- Consumes the speed ramp hitbox produced for the OLED scan. Each frame it checks whether any pixel has both the ramp hitbox and the player car hitbox set.
- On a confirmed overlap it runs a timed boost: hold, then stepwise decay, then cooldown.
- Drives scroll_speed to the obstacle/background scroll logic and boost status to the HUD.
- Sits directly downstream of the speed ramp renderer, in the clock_25mhz domain.

Parameters:
- FRAME_PIXELS, 6144, pixels per frame (96x64); last index is FRAME_PIXELS-1.
- BASE_SPEED, 1, scroll_speed value when not boosted (3-bit).
- BOOST_SPEED, 4, scroll_speed value during HOLD (3-bit, must exceed BASE_SPEED).
- HOLD_CYCLES, 50_000_000, clock_25mhz cycles at BOOST_SPEED (2 s).
- DECAY_STEP_CYCLES, 6_250_000, cycles per one-unit speed decrement in DECAY.
- COOLDOWN_CYCLES, 25_000_000, cycles during which new overlaps are ignored.

Ports:
- clock_25mhz  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pixel_index  input  13  current OLED pixel, 0..FRAME_PIXELS-1
- mode  input  2  game mode; boosts only in 2'b00
- game_active  input  1  game running
- is_speed_ramp_hitbox  input  1  current pixel is a ramp arrow pixel
- is_player_hitbox  input  1  current pixel belongs to the player car
- scroll_speed  output  3  current scroll speed
- boost_active  output  1  high in HOLD or DECAY
- boost_state  output  2  0 IDLE, 1 HOLD, 2 DECAY, 3 COOLDOWN
- boost_count  output  8  accepted boosts, saturating at 255
- frame_tick  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset values: state IDLE; scroll_speed=BASE_SPEED; boost_active=0; boost_state=0; boost_count=0; frame_tick=0. All counters and overlap flags are cleared.
- Frame boundary detection:
  - pixel_index is registered every cycle as prev_idx.
  - frame_tick is asserted in the cycle after prev_idx==FRAME_PIXELS-1 and pixel_index==0.
  - Index holding steady across cycles produces no tick.
- Overlap accumulation:
  - ovl_acc is set in any cycle where is_speed_ramp_hitbox & is_player_hitbox are both high.
  - On the frame boundary, ovl_acc is copied to ovl_frame and cleared in the same cycle.
  - An overlap on the boundary cycle itself goes to the new frame.
- Trigger:
  - trig = ovl_frame & game_active & (mode==2'b00).
  - trig is evaluated in the cycle frame_tick is high, which gives 1-cycle latency from the boundary. ovl_frame is then consumed (cleared).
- FSM (single counter, cnt):
  - IDLE: on trig go to HOLD, cnt=0, scroll_speed=BOOST_SPEED, increment boost_count.
  - HOLD: cnt increments. When cnt==HOLD_CYCLES-1, go to DECAY with cnt=0. On trig, cnt=0 (extend) and boost_count increments.
  - DECAY:
    - When cnt==DECAY_STEP_CYCLES-1, scroll_speed decrements and cnt=0.
    - When the decrement would reach BASE_SPEED, set scroll_speed=BASE_SPEED and go to COOLDOWN, cnt=0.
    - On trig, go to HOLD, scroll_speed=BOOST_SPEED, cnt=0, increment boost_count.
  - COOLDOWN: trig is ignored and not counted. When cnt==COOLDOWN_CYCLES-1, go to IDLE.
- boost_active is registered and equals (state==HOLD || state==DECAY). boost_state mirrors the state encoding.
- game_active low or mode!=2'b00, synchronous and highest priority after reset:
  - state IDLE, scroll_speed=BASE_SPEED, cnt=0, ovl_acc=ovl_frame=0.
  - boost_count is held.
- boost_count saturates at 255 and does not wrap.
- Asynchronous reset mid-boost returns all outputs to reset values immediately.
- Counters are 32-bit; all comparisons are unsigned.

Test Plan:
- Overlap in frame 0 with HOLD_CYCLES=20, DECAY_STEP_CYCLES=5, COOLDOWN_CYCLES=10, BOOST_SPEED=4, BASE_SPEED=1:
  - scroll_speed=4 one cycle after frame_tick.
  - Speed steps 3, 2 at 5-cycle intervals after 20 cycles, then 1.
  - State goes to COOLDOWN, then IDLE after 10 cycles.
  - boost_count=1.
- Second overlap frame during HOLD: HOLD timer restarts (speed stays 4 for 20 more cycles) and boost_count=2.
- Overlap frame during COOLDOWN: no state change and boost_count unchanged. Overlap after return to IDLE re-triggers.
- Overlap with mode=2'b01, or with game_active=0 at the boundary: no boost. Dropping game_active during HOLD forces IDLE and scroll_speed=1 on the next edge.
- 260 triggers separated by full cycles: boost_count reads 255.
- Assert reset mid-DECAY between clock edges: outputs go to reset values without waiting for a clock edge. A pixel_index held at 6143 for 3 cycles and then set to 0 produces exactly one frame_tick.

Source files
------------

// File: rtl/speed_boost_ctrl.sv
// Speed ramp boost controller: per-frame ramp/player overlap detection
// driving a timed hold / stepwise decay / cooldown boost sequence.
//
// Ports:
//   clock_25mhz          system clock
//   reset                asynchronous, active-high reset
//   pixel_index[12:0]    current OLED pixel, 0..FRAME_PIXELS-1
//   mode[1:0]            game mode; boosts only in 2'b00
//   game_active          game running
//   is_speed_ramp_hitbox current pixel is a ramp arrow pixel
//   is_player_hitbox     current pixel belongs to the player car
//   scroll_speed[2:0]    current scroll speed
//   boost_active         high in HOLD or DECAY
//   boost_state[1:0]     0 IDLE, 1 HOLD, 2 DECAY, 3 COOLDOWN
//   boost_count[7:0]     accepted boosts, saturating at 255
//   frame_tick           one-cycle pulse at each frame boundary

module speed_boost_ctrl #(
    parameter int unsigned FRAME_PIXELS      = 6144,
    parameter logic [2:0]  BASE_SPEED        = 3'd1,
    parameter logic [2:0]  BOOST_SPEED       = 3'd4,
    parameter int unsigned HOLD_CYCLES       = 50_000_000,
    parameter int unsigned DECAY_STEP_CYCLES = 6_250_000,
    parameter int unsigned COOLDOWN_CYCLES   = 25_000_000
) (
    input  logic        clock_25mhz,
    input  logic        reset,
    input  logic [12:0] pixel_index,
    input  logic [1:0]  mode,
    input  logic        game_active,
    input  logic        is_speed_ramp_hitbox,
    input  logic        is_player_hitbox,
    output logic [2:0]  scroll_speed,
    output logic        boost_active,
    output logic [1:0]  boost_state,
    output logic [7:0]  boost_count,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_DECAY = 2'd2,
        S_COOL  = 2'd3
    } state_t;

    localparam logic [12:0] LAST_IDX   = 13'(FRAME_PIXELS - 1);
    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] STEP_LAST  = 32'(DECAY_STEP_CYCLES - 1);
    localparam logic [31:0] COOL_LAST  = 32'(COOLDOWN_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cnt;
    logic [31:0] cnt_nxt;
    logic [2:0]  speed_nxt;
    logic [7:0]  count_nxt;
    logic [7:0]  count_inc;
    logic        active_nxt;

    logic [12:0] prev_idx;
    logic        ovl_acc;
    logic        ovl_frame;
    logic        hit;
    logic        boundary;
    logic        enabled;
    logic        trig;
    logic        last_step;

    assign hit      = is_speed_ramp_hitbox & is_player_hitbox;
    assign boundary = (prev_idx == LAST_IDX) && (pixel_index == 13'd0);
    assign enabled  = game_active && (mode == 2'b00);
    assign trig     = frame_tick & ovl_frame & enabled;

    assign boost_state = state;

    // Saturating increment shared by every accepted trigger.
    assign count_inc = (boost_count == 8'hFF) ? boost_count
                                              : boost_count + 8'd1;

    // Next decrement lands on (or below) the base speed.
    assign last_step = ({1'b0, scroll_speed} <= ({1'b0, BASE_SPEED} + 4'd1));

    // Frame boundary and overlap capture. The boundary cycle's own
    // overlap seeds the new frame's accumulator.
    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            prev_idx   <= 13'd0;
            frame_tick <= 1'b0;
            ovl_acc    <= 1'b0;
            ovl_frame  <= 1'b0;
        end else begin
            prev_idx   <= pixel_index;
            frame_tick <= boundary;
            if (!enabled) begin
                ovl_acc   <= 1'b0;
                ovl_frame <= 1'b0;
            end else if (boundary) begin
                ovl_frame <= ovl_acc;
                ovl_acc   <= hit;
            end else begin
                ovl_acc <= ovl_acc | hit;
                if (frame_tick) begin
                    ovl_frame <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= 32'd0;
            scroll_speed <= BASE_SPEED;
            boost_count  <= 8'd0;
            boost_active <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            scroll_speed <= speed_nxt;
            boost_count  <= count_nxt;
            boost_active <= active_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        speed_nxt = scroll_speed;
        count_nxt = boost_count;

        if (!enabled) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 32'd0;
            speed_nxt = BASE_SPEED;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (trig) begin
                        state_nxt = S_HOLD;
                        cnt_nxt   = 32'd0;
                        speed_nxt = BOOST_SPEED;
                        count_nxt = count_inc;
                    end
                end
                S_HOLD: begin
                    if (trig) begin
                        cnt_nxt   = 32'd0;
                        count_nxt = count_inc;
                    end else if (cnt == HOLD_LAST) begin
                        state_nxt = S_DECAY;
                        cnt_nxt   = 32'd0;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                S_DECAY: begin
                    if (trig) begin
                        state_nxt = S_HOLD;
                        cnt_nxt   = 32'd0;
                        speed_nxt = BOOST_SPEED;
                        count_nxt = count_inc;
                    end else if (cnt == STEP_LAST) begin
                        cnt_nxt = 32'd0;
                        if (last_step) begin
                            speed_nxt = BASE_SPEED;
                            state_nxt = S_COOL;
                        end else begin
                            speed_nxt = scroll_speed - 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                S_COOL: begin
                    if (cnt == COOL_LAST) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = 32'd0;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
            endcase
        end

        active_nxt = (state_nxt == S_HOLD) || (state_nxt == S_DECAY);
    end

endmodule
